// File: rtl/aes128_round_engine.sv
// ============================================================================
//  Module      : aes128_round_engine
//  Description : Iterative AES-128 encryption core, one round per clock,
//                valid/ready handshakes on both sides, one block in flight.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module aes128_round_engine (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  plaintext,
    input  logic [1407:0] round_keys,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  ciphertext,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // FIPS-197 S-box, entry 0 in the most significant byte
    localparam logic [0:255][7:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_st;
    logic [127:0]   r_ct;
    logic [3:0]     r_rnd;

    logic [7:0]     w_sb [16];
    logic [7:0]     w_sr [16];
    logic [7:0]     w_mc [16];
    logic [127:0]   w_sr_flat;
    logic [127:0]   w_mc_flat;
    logic [127:0]   w_rk;

    // Byte i of the state lives at [127-8i -: 8]; column c holds bytes 4c..4c+3
    generate
        for (genvar i = 0; i < 16; i++) begin : g_sbox
            assign w_sb[i] = c_sbox[r_st[127-8*i -: 8]];
            assign w_sr_flat[127-8*i -: 8] = w_sr[i];
            assign w_mc_flat[127-8*i -: 8] = w_mc[i];
        end

        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_shift
                assign w_sr[r+4*c] = w_sb[r + 4*((c+r)%4)];
            end

            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_sr[4*c];
            assign w_a1 = w_sr[4*c+1];
            assign w_a2 = w_sr[4*c+2];
            assign w_a3 = w_sr[4*c+3];

            assign w_mc[4*c]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign w_mc[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign w_mc[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign w_mc[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate

    // Key for the round currently executing; keys are read live, not stored
    always_comb begin
        w_rk = round_keys[1279 -: 128];
        for (int r = 1; r <= 10; r++) begin
            if (r_rnd == 4'(r)) begin
                w_rk = round_keys[1407-128*r -: 128];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)          w_next = S_RUN;
            S_RUN:   if (r_rnd == 4'd10)    w_next = S_DONE;
            S_DONE:  if (out_ready)         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st  <= 128'h0;
            r_rnd <= 4'd0;
            r_ct  <= 128'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_st  <= plaintext ^ round_keys[1407 -: 128];
                        r_rnd <= 4'd1;
                    end
                end
                S_RUN: begin
                    // Final round skips MixColumns and lands in the output register
                    if (r_rnd == 4'd10) begin
                        r_ct <= w_sr_flat ^ w_rk;
                    end else begin
                        r_st  <= w_mc_flat ^ w_rk;
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign ciphertext = r_ct;

endmodule

`default_nettype wire

// File: tb/tb_aes128_round_engine.sv
// ============================================================================
//  Module      : tb_aes128_round_engine
//  Description : Scoreboarded random/vector bench with a byte-level AES model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_aes128_round_engine;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  plaintext = 128'h0;
    logic [1407:0] round_keys = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  ciphertext;
    logic          busy;

    aes128_round_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [127:0] ct;
        time          t;
    } exp_t;
    exp_t sbq[$];
    time  t_last_acc = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] c_key_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_key_c = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_pt_c  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct_c  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_ct_z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // ---------------- reference model: GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box derived from the multiplicative inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] bundle;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) bundle[1407-32*i -: 32] = w[i];
        return bundle;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [1407:0] rk;
        logic [127:0]  k;
        logic [127:0]  res;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [7:0]    a0, a1, a2, a3;
        rk = expand(key);
        k  = rk[1407 -: 128];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = s[r + 4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            k = rk[1407-128*rnd -: 128];
            for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, want);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Monitor: latency on each rising out_valid, ciphertext on each transfer
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_ov) begin
            if (sbq.size() == 0) timeout("unexpected_out_valid");
            else check("latency_ns", 128'($time - sbq[0].t), 128'd105);
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                timeout("unexpected_transfer");
            end else begin
                e = sbq.pop_front();
                check("ciphertext", ciphertext, e.ct);
            end
        end
        prev_ov <= out_valid;
    end

    // ---------------- stimulus helpers (inputs change 1ns after posedge) ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        int   guard = 0;
        logic rdy;
        logic done = 1'b0;
        while (busy && !out_valid && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        plaintext  = pt;
        round_keys = expand(key);
        in_valid   = 1'b1;
        guard      = 0;
        while (!done) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                sbq.push_back('{ct: encrypt(pt, key), t: $time});
                t_last_acc = $time;
                done = 1'b1;
            end else if (++guard > 100) begin
                timeout("accept");
                done = 1'b1;
            end
            #1;
        end
    endtask

    task automatic wait_ov();
        int guard = 0;
        while (!out_valid && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        if (!out_valid) timeout("wait_out_valid");
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(in_ready && !out_valid) && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) timeout("wait_idle");
    endtask

    initial begin
        time t_first;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,   1);
        check("rst_out_valid", out_valid,  0);
        check("rst_busy",      busy,       0);
        check("rst_ct",        ciphertext, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        send(c_pt_b, c_key_b);
        in_valid = 1'b0;
        wait_idle();
        check("appB_ct", ciphertext, c_ct_b);

        send(c_pt_c, c_key_c);
        in_valid = 1'b0;
        wait_idle();
        check("appC1_ct", ciphertext, c_ct_c);

        // Backpressure with an ignored in_valid pulse
        out_ready = 1'b0;
        send(128'h0, 128'h0);
        in_valid = 1'b0;
        wait_ov();
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", out_valid,  1);
            check("bp_ct",        ciphertext, c_ct_z);
            if (i == 5) begin
                check("bp_in_ready", in_ready, 0);
                plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_valid  = 1'b1;
            end
            if (i == 6) begin
                check("bp_in_ready_after", in_ready, 0);
                check("bp_busy", busy, 1);
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready,  1);

        // Back-to-back blocks with in_valid held high
        send(c_pt_b, c_key_b);
        t_first = t_last_acc;
        send(c_pt_c, c_key_c);
        check("b2b_spacing_ns", 128'(t_last_acc - t_first), 128'd120);
        in_valid = 1'b0;
        wait_idle();
        check("b2b_last_ct", ciphertext, c_ct_c);

        // Reset in the middle of a block
        send(c_pt_b, c_key_b);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid,  0);
        check("midrst_busy",      busy,       0);
        check("midrst_in_ready",  in_ready,   1);
        check("midrst_ct",        ciphertext, 0);
        send(c_pt_b, c_key_b);
        in_valid = 1'b0;
        wait_idle();
        check("post_rst_appB_ct", ciphertext, c_ct_b);

        // Random blocks, plaintext scrambled right after acceptance
        for (int k = 0; k < 6; k++) begin
            out_ready = k[0] ? 1'b0 : 1'b1;
            send({$urandom(), $urandom(), $urandom(), $urandom()},
                 {$urandom(), $urandom(), $urandom(), $urandom()});
            plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid  = 1'b0;
            if (!out_ready) begin
                wait_ov();
                repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(sbq.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
